// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   cmp_state_e : FSM state encoding (IDLE / SCAN / DONE), also exported on
//                 the top-level debug port.
//   RES_*       : bit positions of the eq/gt/lt flags in the result vector.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_e;

  localparam int RES_EQ = 0;
  localparam int RES_GT = 1;
  localparam int RES_LT = 2;
  localparam int RES_W  = 3;

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result bundle for seq_magnitude_comparator.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holds valid and its payload
// steady until that edge; ready may change freely and carries no payload.
//   input channel  : in_valid / in_ready, payload a, b, signed_mode
//   output channel : out_valid / out_ready, payload eq, gt, lt
//
// Modports:
//   master : the side that offers operands and consumes results
//   slave  : the comparator
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, eq, gt, lt
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, eq, gt, lt
  );
endinterface

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
//   a, b : slice operands
//   eq   : a == b
//   gt   : a >  b
//   lt   : a <  b
module cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = (a >  b);
  assign lt = (a <  b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator: compares two WIDTH-bit operands one
// DIGIT-bit slice per cycle, most significant slice first, stopping at the
// first slice that differs.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   bus       : operand/result handshake bundle (slave side)
//   state_dbg : current FSM state
// Parameters: WIDTH operand width, DIGIT slice width (WIDTH must be a
// multiple of DIGIT).
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_magnitude_comparator_if.slave   bus,
  output cmp_state_e                  state_dbg
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  cmp_state_e       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [RES_W-1:0] res_q, res_d;
  logic             load;

  logic [DIGIT-1:0] a_slice, b_slice;
  logic             d_eq, d_gt, d_lt;

  // Single slice comparator fed by the slice at the current index.
  assign a_slice = a_q[idx_q*DIGIT +: DIGIT];
  assign b_slice = b_q[idx_q*DIGIT +: DIGIT];

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (a_slice),
    .b  (b_slice),
    .eq (d_eq),
    .gt (d_gt),
    .lt (d_lt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          idx_d   = IDX_TOP;
          res_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!d_eq) begin
          res_d         = '0;
          res_d[RES_GT] = d_gt;
          res_d[RES_LT] = d_lt;
          state_d       = ST_DONE;
        end else if (idx_q == '0) begin
          res_d         = '0;
          res_d[RES_EQ] = 1'b1;
          state_d       = ST_DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          res_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        res_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      if (load) begin
        // Flipping the sign bit maps two's-complement order onto unsigned
        // order, so the slice scan itself never needs to know the mode.
        a_q <= bus.a ^ (bus.signed_mode ? MSB_MASK : '0);
        b_q <= bus.b ^ (bus.signed_mode ? MSB_MASK : '0);
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  // res_q is cleared outside DONE; the gating keeps the flags low even so.
  assign bus.eq = bus.out_valid & res_q[RES_EQ];
  assign bus.gt = bus.out_valid & res_q[RES_GT];
  assign bus.lt = bus.out_valid & res_q[RES_LT];

  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4).
module tb_seq_magnitude_comparator;
  import cmp_pkg::*;

  localparam int WIDTH   = 16;
  localparam int DIGIT   = 4;
  localparam int NDIG    = WIDTH / DIGIT;
  localparam int MAX_CYC = 50;

  localparam logic [2:0] F_EQ = 3'b001;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_LT = 3'b100;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  cmp_state_e state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

  seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];
  int         exp_k_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] flags();
    return {bus.lt, bus.gt, bus.eq};
  endfunction

  // Reference model: numeric compare, and k = slices down to the most
  // significant differing bit (all slices when the operands are equal).
  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic sm,
                                output logic [2:0] f, output int k);
    logic [15:0] d;
    int top;
    if (sm) f = ($signed(x) > $signed(y)) ? F_GT : ($signed(x) < $signed(y)) ? F_LT : F_EQ;
    else    f = (x > y) ? F_GT : (x < y) ? F_LT : F_EQ;
    d   = x ^ y;
    top = -1;
    for (int i = 0; i < WIDTH; i++) if (d[i]) top = i;
    k = (top < 0) ? NDIG : NDIG - (top / DIGIT);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_cmp(input logic [15:0] ta, input logic [15:0] tb_v, input logic tsm,
                         input int hold, input bit scramble);
    logic [2:0] ef;
    int ek;
    int cycles;
    logic [2:0] held;
    model(ta, tb_v, tsm, ef, ek);
    exp_q.push_back(ef);
    exp_k_q.push_back(ek);
    @(negedge clk);
    bus.a           = ta;
    bus.b           = tb_v;
    bus.signed_mode = tsm;
    bus.in_valid    = 1'b1;
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cycles = 0;
    while (!bus.out_valid && cycles < MAX_CYC) begin
      check("flags_low_while_busy", 32'(flags()), 32'd0);
      if (scramble) begin
        bus.a           = 16'($urandom);
        bus.b           = 16'($urandom);
        bus.signed_mode = 1'($urandom);
      end
      @(posedge clk);
      #1 cycles++;
    end
    ef = exp_q.pop_front();
    ek = exp_k_q.pop_front();
    if (!bus.out_valid) begin
      check("result_timeout", 32'(bus.out_valid), 32'd1);
      return;
    end
    check("latency_k", 32'(cycles), 32'(ek));
    check("result_flags", 32'(flags()), 32'(ef));
    held = flags();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_flags", 32'(flags()), 32'(held));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("idle_after_release", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    check("flags_after_release", 32'(flags()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ra, rb;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;
    do_reset();

    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_flags", 32'(flags()), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));

    // Directed cases.
    run_cmp(16'h1234, 16'h1234, 1'b0, 0, 1'b0);
    run_cmp(16'h8000, 16'h7FFF, 1'b0, 0, 1'b0);
    run_cmp(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0);
    run_cmp(16'h1235, 16'h1234, 1'b0, 0, 1'b0);
    run_cmp(16'hFFFF, 16'hFFFE, 1'b1, 0, 1'b0);
    run_cmp(16'h0000, 16'hFFFF, 1'b1, 0, 1'b0);
    run_cmp(16'h0000, 16'hFFFF, 1'b0, 0, 1'b0);
    run_cmp(16'h8000, 16'h8000, 1'b1, 0, 1'b0);
    // Result held back by the consumer for three cycles.
    run_cmp(16'h4321, 16'h4311, 1'b0, 3, 1'b0);
    // Operands wiggled every cycle while scanning.
    run_cmp(16'hA5A5, 16'hA5A5, 1'b1, 0, 1'b1);
    run_cmp(16'h7001, 16'h7002, 1'b0, 1, 1'b1);

    // Reset in the middle of a scan, with the index at 2.
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h1234; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    check("scan_before_reset", 32'(state_dbg), 32'(ST_SCAN));
    @(posedge clk);
    #1 rst = 1'b0;
    check("midscan_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midscan_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midscan_rst_flags", 32'(flags()), 32'd0);
    repeat (5) @(posedge clk);
    #1 check("discarded_no_result", 32'(bus.out_valid), 32'd0);
    run_cmp(16'd3, 16'd5, 1'b0, 0, 1'b0);

    // Randomized traffic: random pairs, equal pairs, and single-bit differences.
    for (int n = 0; n < 60; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (16'd1 << $urandom_range(0, 15));
      endcase
      run_cmp(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_magnitude_comparator.md
SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4: bits compared per cycle; WIDTH mod DIGIT = 0; NDIG = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement compare; 0 = unsigned compare.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have ports eq, gt and lt, output, 1 bit each: a==b, a>b and a<b respectively.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, SCAN and DONE; in_ready = 1 only in IDLE.
REQ-013 On an edge with in_valid & in_ready, the block SHALL register a, b and signed_mode, set digit index to NDIG-1 and go to SCAN.
REQ-014 With signed_mode = 1, the block SHALL invert bit WIDTH-1 of both registered operands at capture, so that an unsigned scan gives the signed order.
REQ-015 Each SCAN cycle SHALL compare exactly one DIGIT-bit slice, MSB slice first, at the current index.
REQ-016 If the slices differ, the block SHALL go to DONE on that edge, with gt/lt taken from the slice compare.
REQ-017 If the slices are equal and index > 0, the block SHALL decrement the index and stay in SCAN.
REQ-018 If the slices are equal and index = 0, the block SHALL go to DONE with eq = 1.
REQ-019 Latency: out_valid SHALL rise k edges after the accept edge, where k = number of slices examined; 1 <= k <= NDIG (early termination).
REQ-020 In DONE, out_valid SHALL be 1 and exactly one of eq/gt/lt SHALL be 1; outputs SHALL hold stable until an edge with out_ready = 1.
REQ-021 On an edge in DONE with out_ready = 1, the block SHALL go to IDLE; a new accept is possible no earlier than the following edge.
REQ-022 eq, gt and lt SHALL be 0 whenever out_valid = 0.
REQ-023 Changes on a, b or signed_mode after the accept edge SHALL have no effect on the result in progress.
REQ-024 When DIGIT = WIDTH (NDIG = 1), the block SHALL complete with k = 1 for every operand pair.

Reset
REQ-025 An edge with rst = 1 SHALL put the block in IDLE, with out_valid = 0, eq = gt = lt = 0, in_ready = 1 after that edge, from any state including mid-SCAN and DONE.
REQ-026 rst SHALL take priority over any handshake on the same edge; an operation in progress SHALL be discarded without a result.

Structure
REQ-027 State encodings (IDLE/SCAN/DONE) SHALL live in a shared package, cmp_pkg, together with the result-flag index constants.
REQ-028 Per-slice comparison SHALL be a combinational sub-module, cmp_digit, parameterised by DIGIT, with outputs eq/gt/lt.
REQ-029 The design SHALL use one instance of cmp_digit, driven by a multiplexed slice selected by the digit index.

Verification (WIDTH=16, DIGIT=4)
REQ-030 The bench SHALL cover: a=0x1234, b=0x1234, unsigned -> eq=1, k=4, gt=lt=0.
REQ-031 The bench SHALL cover: a=0x8000, b=0x7FFF -> unsigned gives gt=1 at k=1; signed gives lt=1 at k=1.
REQ-032 The bench SHALL cover: a=0x1235, b=0x1234, unsigned -> gt=1 at k=4; a=0xFFFF (-1), b=0xFFFE (-2), signed -> gt=1 at k=4.
REQ-033 The bench SHALL cover: result with out_ready held 0 for 3 cycles -> out_valid, eq/gt/lt stable throughout; IDLE one edge after out_ready=1.
REQ-034 The bench SHALL cover: rst=1 during SCAN (index 2) -> next cycle in IDLE, out_valid=0, in_ready=1; a following compare a=3, b=5 gives lt=1.
REQ-035 The bench SHALL cover: a and b changed every cycle during SCAN -> the result matches the operands captured at the accept edge.
